// File: rtl/fetch_queue_pkg.sv
// Shared front-end types: the decode-side NOP encoding and the {pc, instr} entry
// carried from fetch into the FetchDecode pipeline register.
package fetch_queue_pkg;

   localparam int unsigned CPU_DATA_W = 16;
   localparam int unsigned CPU_ADDR_W = 16;

   localparam logic [CPU_DATA_W-1:0] NOP_INSTR = 16'h0000;

   typedef struct packed {
      logic [CPU_ADDR_W-1:0] pc;
      logic [CPU_DATA_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-queue bus: decode-side control, ROM address/data and the head-of-queue outputs.
interface fetch_queue_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 16
);
   logic              stall;
   logic              flush;
   logic [ADDR_W-1:0] flush_target;
   logic [ADDR_W-1:0] rom_address;
   logic [DATA_W-1:0] rom_q;
   logic              instr_valid;
   logic [DATA_W-1:0] instr_out;
   logic [ADDR_W-1:0] pc_out;

   modport master (
      output stall, flush, flush_target, rom_q,
      input  rom_address, instr_valid, instr_out, pc_out
   );

   modport slave (
      input  stall, flush, flush_target, rom_q,
      output rom_address, instr_valid, instr_out, pc_out
   );
endinterface

// File: rtl/fetch_queue_chk.sv
// Runtime checks for the fetch queue: the credit rule must never let a ROM
// return land on a full FIFO.
module fetch_queue_chk (
   input logic clk_i,
   input logic reset_ni,
   input logic push_i,
   input logic full_i
);
   a_no_push_when_full: assert property (@(posedge clk_i) disable iff (!reset_ni)
      !(push_i && full_i))
      else $error("fetch_queue: ROM return pushed into a full FIFO");
endmodule

// File: rtl/fetch_queue_sync_fifo.sv
// Generic synchronous FIFO with occupancy count and a one-cycle clear.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_queue_sync_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     reset_ni,
   input  logic                     clear_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     empty_o,
   output logic                     full_o
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W:0]   count_q;
   logic             do_push_s;
   logic             do_pop_s;

   assign empty_o   = (count_q == '0);
   assign full_o    = (count_q == FULL_CNT);
   assign count_o   = count_q;
   assign rdata_o   = mem_q[rd_ptr_q];
   assign do_pop_s  = pop_i && !empty_o;
   // A write into a full FIFO is only accepted when the head leaves on the same edge.
   assign do_push_s = push_i && (!full_o || do_pop_s);

   always_ff @(posedge clk_i) begin
      if (!reset_ni || clear_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push_s) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop_s)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push_s, do_pop_s})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push_s && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
   end
endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues sequential ROM reads, tags them with their PC,
// and buffers returns so decode stalls never force a re-fetch.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int unsigned       DATA_W   = 16,
   parameter int unsigned       ADDR_W   = 16,
   parameter int unsigned       DEPTH    = 4,
   parameter int unsigned       ROM_LAT  = 1,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input logic          clk_i,
   input logic          reset_ni,
   fetch_queue_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
   localparam int unsigned SUM_W = CNT_W + 1;
   localparam logic [SUM_W-1:0] DEPTH_L = SUM_W'(DEPTH);

   logic [ADDR_W-1:0]              fetch_pc_q, fetch_pc_d;
   logic [ROM_LAT-1:0]             tag_vld_q, tag_vld_d;
   logic [ROM_LAT-1:0][ADDR_W-1:0] tag_pc_q, tag_pc_d;

   logic [CNT_W-1:0]         occ_s;
   logic [CNT_W-1:0]         inflight_s;
   logic [SUM_W-1:0]         credit_s;
   logic                     issue_s;
   logic                     push_s;
   logic                     pop_s;
   logic                     empty_s;
   logic                     full_s;
   logic [ADDR_W+DATA_W-1:0] head_s;

   // Count reads still travelling through the ROM.
   always_comb begin
      inflight_s = '0;
      for (int i = 0; i < ROM_LAT; i++) begin
         inflight_s = inflight_s + CNT_W'(tag_vld_q[i]);
      end
   end

   // Credit uses pre-edge occupancy, so a pop in this cycle is not yet counted as free space.
   assign credit_s = {1'b0, occ_s} + {1'b0, inflight_s};
   assign issue_s  = !bus.flush && (credit_s < DEPTH_L);
   assign push_s   = tag_vld_q[ROM_LAT-1];
   assign pop_s    = !empty_s && !bus.stall;

   // Next fetch PC and tag pipeline; flush drops every in-flight tag.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      tag_vld_d  = '0;
      tag_pc_d   = '0;
      if (bus.flush) begin
         fetch_pc_d = bus.flush_target;
      end else begin
         if (issue_s) begin
            tag_vld_d[0] = 1'b1;
            tag_pc_d[0]  = fetch_pc_q;
            fetch_pc_d   = fetch_pc_q + 1'b1;
         end else begin
            tag_vld_d[0] = 1'b0;
            tag_pc_d[0]  = '0;
         end
         for (int i = 1; i < ROM_LAT; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_pc_d[i]  = tag_pc_q[i-1];
         end
      end
   end

   // Fetch PC and tag registers.
   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         fetch_pc_q <= RESET_PC;
         tag_vld_q  <= '0;
         tag_pc_q   <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         tag_vld_q  <= tag_vld_d;
         tag_pc_q   <= tag_pc_d;
      end
   end

   fetch_queue_sync_fifo #(
      .WIDTH (ADDR_W + DATA_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .clear_i  (bus.flush),
      .push_i   (push_s),
      .pop_i    (pop_s),
      .wdata_i  ({tag_pc_q[ROM_LAT-1], bus.rom_q}),
      .rdata_o  (head_s),
      .count_o  (occ_s),
      .empty_o  (empty_s),
      .full_o   (full_s)
   );

   fetch_queue_chk u_chk (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .push_i   (push_s && !bus.flush),
      .full_i   (full_s)
   );

   assign bus.rom_address = fetch_pc_q;
   assign bus.instr_valid = !empty_s;

   // Head entry is masked to NOP / PC 0 whenever the queue is empty.
   always_comb begin
      bus.instr_out = DATA_W'(NOP_INSTR);
      bus.pc_out    = '0;
      if (!empty_s) begin
         bus.instr_out = head_s[DATA_W-1:0];
         bus.pc_out    = head_s[ADDR_W+DATA_W-1:DATA_W];
      end else begin
         bus.instr_out = DATA_W'(NOP_INSTR);
         bus.pc_out    = '0;
      end
   end
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: cycle-exact vector table on a ROM_LAT=1 instance, then a
// scoreboarded stream on a ROM_LAT=2 instance.
module tb_fetch_queue;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a_n, rst_b_n;
   logic [15:0] rom_a_q, rom_b1_q, rom_b2_q;
   int          n_vec = 0;
   int          n_err = 0;
   logic [15:0] exp_q[$];

   fetch_queue_if #(.DATA_W(16), .ADDR_W(16)) if_a ();
   fetch_queue_if #(.DATA_W(16), .ADDR_W(16)) if_b ();

   fetch_queue #(.DATA_W(16), .ADDR_W(16), .DEPTH(4), .ROM_LAT(1), .RESET_PC(16'h0000))
      dut_a (.clk_i(clk), .reset_ni(rst_a_n), .bus(if_a));
   fetch_queue #(.DATA_W(16), .ADDR_W(16), .DEPTH(4), .ROM_LAT(2), .RESET_PC(16'h0000))
      dut_b (.clk_i(clk), .reset_ni(rst_b_n), .bus(if_b));

   function automatic logic [15:0] rom_fn(input logic [15:0] a);
      return a + 16'h1000;
   endfunction

   // ROM models: one and two cycles of read latency.
   always @(posedge clk) begin
      rom_a_q  <= rom_fn(if_a.rom_address);
      rom_b1_q <= rom_fn(if_b.rom_address);
      rom_b2_q <= rom_b1_q;
   end
   assign if_a.rom_q = rom_a_q;
   assign if_b.rom_q = rom_b2_q;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        rst_n;
      logic        stall;
      logic        flush;
      logic [15:0] tgt;
      logic        v;
      logic [15:0] pc;
      logic [15:0] rom;
   } vec_t;
   vec_t vecs[$];

   task automatic add(input logic rst_n, input logic stall, input logic flush,
                      input logic [15:0] tgt, input logic v, input logic [15:0] pc,
                      input logic [15:0] rom);
      vec_t t;
      t.rst_n = rst_n; t.stall = stall; t.flush = flush; t.tgt = tgt;
      t.v = v; t.pc = pc; t.rom = rom;
      vecs.push_back(t);
   endtask

   // Runs dut_b from a negedge; pops the scoreboard whenever the head will be consumed.
   task automatic run_b(input int ncyc, input int s_lo, input int s_hi);
      logic [15:0] exp_pc;
      for (int c = 0; c < ncyc; c++) begin
         if_b.stall = (c >= s_lo && c < s_hi);
         if (if_b.instr_valid && !if_b.stall) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL b_sb_empty: got pc %h, expected no instruction", if_b.pc_out);
            end else begin
               exp_pc = exp_q.pop_front();
               check($sformatf("b_pc_c%0d", c), if_b.pc_out, exp_pc);
               check($sformatf("b_instr_c%0d", c), if_b.instr_out, rom_fn(exp_pc));
            end
         end
         @(posedge clk);
         #1;
         check($sformatf("b_valid_c%0d", c), {15'h0000, if_b.instr_valid}, {15'h0000, c >= 2});
         @(negedge clk);
      end
   endtask

   initial begin
      rst_a_n = 1'b0; rst_b_n = 1'b0;
      if_a.stall = 1'b0; if_a.flush = 1'b0; if_a.flush_target = 16'h0000;
      if_b.stall = 1'b0; if_b.flush = 1'b0; if_b.flush_target = 16'h0000;
      repeat (2) @(posedge clk);
      @(negedge clk);

      //  rst stall flush target   valid pc       rom_address
      add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000);
      add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000);
      add(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0001);
      add(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0002);
      add(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0001, 16'h0003);
      add(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0002, 16'h0004);
      add(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002, 16'h0005);
      add(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002, 16'h0006);
      add(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002, 16'h0006);
      add(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002, 16'h0006);
      add(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002, 16'h0006);
      add(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002, 16'h0006);
      add(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0003, 16'h0006);
      add(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0004, 16'h0007);
      add(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0005, 16'h0008);
      add(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0006, 16'h0009);
      add(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0007, 16'h000A);
      add(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0007, 16'h000B);
      add(1'b1, 1'b0, 1'b1, 16'h0040, 1'b0, 16'h0000, 16'h0040);
      add(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0041);
      add(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0040, 16'h0042);
      add(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0041, 16'h0043);
      add(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0042, 16'h0044);
      add(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0042, 16'h0045);
      add(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0042, 16'h0046);
      add(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0042, 16'h0046);
      add(1'b1, 1'b1, 1'b1, 16'h0080, 1'b0, 16'h0000, 16'h0080);
      add(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0081);
      add(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0080, 16'h0082);
      add(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0081, 16'h0083);
      add(1'b1, 1'b0, 1'b1, 16'hFFFE, 1'b0, 16'h0000, 16'hFFFE);
      add(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'hFFFF);
      add(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hFFFE, 16'h0000);
      add(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hFFFF, 16'h0001);
      add(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0002);
      add(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0001, 16'h0003);
      add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000);
      add(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0001);
      add(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0002);
      add(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0001, 16'h0003);

      for (int i = 0; i < vecs.size(); i++) begin
         rst_a_n           = vecs[i].rst_n;
         if_a.stall        = vecs[i].stall;
         if_a.flush        = vecs[i].flush;
         if_a.flush_target = vecs[i].tgt;
         @(posedge clk);
         #1;
         check($sformatf("a_valid_r%0d", i), {15'h0000, if_a.instr_valid}, {15'h0000, vecs[i].v});
         check($sformatf("a_pc_r%0d", i), if_a.pc_out, vecs[i].pc);
         check($sformatf("a_instr_r%0d", i), if_a.instr_out,
               vecs[i].v ? rom_fn(vecs[i].pc) : 16'h0000);
         check($sformatf("a_rom_r%0d", i), if_a.rom_address, vecs[i].rom);
         @(negedge clk);
      end
      rst_a_n = 1'b0; if_a.stall = 1'b0; if_a.flush = 1'b0;

      // ROM_LAT=2 stream with a three-cycle stall in the middle.
      for (int k = 0; k < 32; k++) exp_q.push_back(16'(k));
      rst_b_n = 1'b1;
      run_b(24, 8, 11);
      check("b_popped_run1", 16'(exp_q.size()), 16'd14);

      // Reset mid-stream, then restart from RESET_PC.
      rst_b_n = 1'b0;
      if_b.stall = 1'b0;
      @(posedge clk);
      #1;
      check("b_rst_valid", {15'h0000, if_b.instr_valid}, 16'h0000);
      check("b_rst_pc", if_b.pc_out, 16'h0000);
      check("b_rst_instr", if_b.instr_out, 16'h0000);
      check("b_rst_rom", if_b.rom_address, 16'h0000);
      @(negedge clk);
      exp_q.delete();
      for (int k = 0; k < 16; k++) exp_q.push_back(16'(k));
      rst_b_n = 1'b1;
      run_b(8, 0, 0);
      check("b_popped_run2", 16'(exp_q.size()), 16'd11);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
